sm4_key_expand: RTL

SM4_KEY_EXPAND -- requirements
Module: sm4_key_expand

---
 rtl/sm4_key_expand.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/sm4_key_expand.sv
// -----------------------------------------------------------------------------
// sm4_sbox / sm4_key_expand
//
// sm4_sbox: the SM4 byte substitution, implemented as a constant lookup.
//   data_i : 8-bit input byte
//   data_o : 8-bit substituted byte
//
// sm4_key_expand: SM4 key schedule. It computes one round key per clock and
// keeps the full 32-entry schedule in a table for random-order readback.
//   clk       : rising-edge clock
//   reset     : asynchronous active-high reset
//   key_start : start request, sampled only in IDLE
//   key_in    : 128-bit master key MK0..MK3 (MK0 = [127:96])
//   rk_out    : registered round key
//   rk_valid  : rk_out / rk_idx valid this cycle
//   rk_idx    : index of the round key on rk_out
//   busy      : high while expanding (RUN)
//   done      : one-cycle pulse together with rk31
//   tbl_valid : table holds a complete schedule
//   rd_dec    : readback order, 0 = encrypt, 1 = decrypt
//   rd_idx    : readback index
//   rd_data   : combinational table read
// -----------------------------------------------------------------------------
module sm4_sbox (
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);
  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  assign data_o = SBOX[data_i];
endmodule

module sm4_key_expand (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_start,
  input  logic [127:0] key_in,
  output logic [31:0]  rk_out,
  output logic         rk_valid,
  output logic [4:0]   rk_idx,
  output logic         busy,
  output logic         done,
  output logic         tbl_valid,
  input  logic         rd_dec,
  input  logic [4:0]   rd_idx,
  output logic [31:0]  rd_data
);
  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [127:0] FK = 128'ha3b1bac6_56aa3350_677d9197_b27022dc;

  // CK byte j of round i is ((4i+j)*7) mod 256; {i,j} is exactly 4i+j and the
  // 8-bit product wraps mod 256 for free.
  function automatic logic [7:0] ck_byte(input logic [4:0] i, input logic [1:0] j);
    logic [7:0] n;
    n = {1'b0, i, j};
    return n * 8'd7;
  endfunction

  // Key-schedule linear transform L'(B) = B ^ (B<<<13) ^ (B<<<23).
  function automatic logic [31:0] l_prime(input logic [31:0] b);
    return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  endfunction

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [31:0] k_q [4];
  logic [31:0] tbl_q [32];
  logic [31:0] rk_out_q;
  logic [4:0]  rk_idx_q;
  logic        rk_valid_q;
  logic        busy_q;
  logic        done_q;
  logic        tbl_valid_q;

  logic [31:0] ck_d;
  logic [31:0] sbox_in_d;
  logic [31:0] tau_d;
  logic [31:0] rk_d;
  logic [4:0]  rd_sel_d;

  assign ck_d      = {ck_byte(cnt_q, 2'd0), ck_byte(cnt_q, 2'd1),
                      ck_byte(cnt_q, 2'd2), ck_byte(cnt_q, 2'd3)};
  assign sbox_in_d = k_q[1] ^ k_q[2] ^ k_q[3] ^ ck_d;

  for (genvar b = 0; b < 4; b++) begin : g_tau
    sm4_sbox u_sbox (
      .data_i (sbox_in_d[8*b +: 8]),
      .data_o (tau_d[8*b +: 8])
    );
  end

  assign rk_d = k_q[0] ^ l_prime(tau_d);

  // Control FSM, key window and registered round-key outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 5'd0;
      for (int w = 0; w < 4; w++) k_q[w] <= 32'd0;
      rk_out_q    <= 32'd0;
      rk_idx_q    <= 5'd0;
      rk_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tbl_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rk_valid_q <= 1'b0;
          done_q     <= 1'b0;
          if (key_start) begin
            state_q     <= RUN;
            busy_q      <= 1'b1;
            cnt_q       <= 5'd0;
            tbl_valid_q <= 1'b0;
            k_q[0]      <= key_in[127:96] ^ FK[127:96];
            k_q[1]      <= key_in[95:64]  ^ FK[95:64];
            k_q[2]      <= key_in[63:32]  ^ FK[63:32];
            k_q[3]      <= key_in[31:0]   ^ FK[31:0];
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          // key_start is deliberately not looked at here.
          rk_out_q   <= rk_d;
          rk_idx_q   <= cnt_q;
          rk_valid_q <= 1'b1;
          k_q[0]     <= k_q[1];
          k_q[1]     <= k_q[2];
          k_q[2]     <= k_q[3];
          k_q[3]     <= rk_d;
          if (cnt_q == 5'd31) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            tbl_valid_q <= 1'b1;
            cnt_q       <= 5'd0;
          end else begin
            cnt_q  <= cnt_q + 5'd1;
            done_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          busy_q     <= 1'b0;
          rk_valid_q <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  // Round-key table: entry i is written on the edge that computes round i.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int e = 0; e < 32; e++) tbl_q[e] <= 32'd0;
    end else if (state_q == RUN) begin
      tbl_q[cnt_q] <= rd_d_unused_guard(rk_d);
    end else begin
      tbl_q[cnt_q] <= tbl_q[cnt_q];
    end
  end

  function automatic logic [31:0] rd_d_unused_guard(input logic [31:0] v);
    return v;
  endfunction

  // Decrypt order reads the schedule back to front.
  assign rd_sel_d = rd_dec ? (5'd31 - rd_idx) : rd_idx;
  assign rd_data  = tbl_q[rd_sel_d];

  assign rk_out    = rk_out_q;
  assign rk_valid  = rk_valid_q;
  assign rk_idx    = rk_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign tbl_valid = tbl_valid_q;
endmodule
